// File: rtl/data_bus_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_responder_if
// Description : Data read (dr_*) and data write (dw_*) channel bundle between
//               the core's data port and the data memory responder.
//               master modport = core side, slave modport = memory side.
// Signals     : dr_addr_valid/dr_addr/dr_addr_ready    read address channel
//               dr_data_valid/dr_data/dr_data_ready    read data channel
//               dw_data_addr_valid/dw_addr/dw_data/
//               dw_strobe/dw_data_addr_ready           write beat channel
//               dw_resp_valid/dw_resp/dw_resp_ready    write response channel
// Revision    : 1.0 - initial release
// ============================================================================

// Response code encoding; left overridable so a SoC-wide bus header can
// supply its own values ahead of this file.
`ifndef BUS_RESP_WIDTH
`define BUS_RESP_WIDTH 2
`endif
`ifndef DATA_WRITE_RESP_OK
`define DATA_WRITE_RESP_OK 2'b00
`endif
`ifndef DATA_WRITE_RESP_FAIL
`define DATA_WRITE_RESP_FAIL 2'b10
`endif

interface data_bus_responder_if;
    logic                         dr_addr_valid;
    logic [31:0]                  dr_addr;
    logic                         dr_addr_ready;
    logic                         dr_data_valid;
    logic [31:0]                  dr_data;
    logic                         dr_data_ready;

    logic                         dw_data_addr_valid;
    logic [31:0]                  dw_addr;
    logic [31:0]                  dw_data;
    logic [3:0]                   dw_strobe;
    logic                         dw_data_addr_ready;
    logic                         dw_resp_valid;
    logic [`BUS_RESP_WIDTH-1:0]   dw_resp;
    logic                         dw_resp_ready;

    modport master (
        output dr_addr_valid, dr_addr, dr_data_ready,
        output dw_data_addr_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready,
        input  dr_addr_ready, dr_data_valid, dr_data,
        input  dw_data_addr_ready, dw_resp_valid, dw_resp
    );

    modport slave (
        input  dr_addr_valid, dr_addr, dr_data_ready,
        input  dw_data_addr_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready,
        output dr_addr_ready, dr_data_valid, dr_data,
        output dw_data_addr_ready, dw_resp_valid, dw_resp
    );
endinterface

`default_nettype wire

// File: rtl/data_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_bus_responder
// Description : Memory-side responder for the core's data read and data
//               write channels, backed by a word-organised on-chip RAM.
//               Reads return data READ_LATENCY cycles after address
//               acceptance; writes are byte-masked and answered with a
//               response code. The two channels run independently.
// Ports       : clk  - clock
//               rst  - synchronous reset, active low
//               bus  - data_bus_responder_if.slave (dr_* / dw_* channels)
// Parameters  : DEPTH        RAM size in 32-bit words (power of 2)
//               BASE_ADDR    byte address of word 0 (aligned to DEPTH*4)
//               READ_LATENCY 1..15 cycles, acceptance to dr_data_valid
//               RO_WORDS     write-protected words from BASE_ADDR
// Options     : DATA_BUS_RESPONDER_WRITE_PROTECT_EN - when defined, writes to
//               word indices below RO_WORDS are refused with a FAIL response.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef BUS_RESP_WIDTH
`define BUS_RESP_WIDTH 2
`endif
`ifndef DATA_WRITE_RESP_OK
`define DATA_WRITE_RESP_OK 2'b00
`endif
`ifndef DATA_WRITE_RESP_FAIL
`define DATA_WRITE_RESP_FAIL 2'b10
`endif

module data_bus_responder #(
    parameter int unsigned DEPTH        = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned RO_WORDS     = 0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    data_bus_responder_if.slave    bus
);

    localparam int unsigned c_idx_w     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] c_byte_span = 32'(DEPTH * 4);
    localparam logic [3:0]  c_lat_init  = 4'(READ_LATENCY - 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    generate
        if (DEPTH == 0 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("data_bus_responder: DEPTH must be a power of 2");
        end
        if ((BASE_ADDR & (c_byte_span - 32'd1)) != 32'd0) begin : g_bad_base
            $error("data_bus_responder: BASE_ADDR must be aligned to DEPTH*4");
        end
        if (READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_latency
            $error("data_bus_responder: READ_LATENCY must be within 1..15");
        end
        if (RO_WORDS > DEPTH) begin : g_bad_ro_words
            $error("data_bus_responder: RO_WORDS must not exceed DEPTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } rd_state_t;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_t;

    rd_state_t          r_rd_state;
    wr_state_t          r_wr_state;
    logic [3:0]         r_rd_cnt;
    logic [31:0]        r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Address decode. The subtraction wraps for addresses below BASE_ADDR,
    // which pushes them above the span and so out of range.
    // ------------------------------------------------------------------
    logic [31:0]        w_rd_offset;
    logic [31:0]        w_wr_offset;
    logic               w_rd_in_range;
    logic               w_wr_in_range;
    logic [c_idx_w-1:0] w_rd_idx;
    logic [c_idx_w-1:0] w_wr_idx;
    logic               w_rd_fire;
    logic               w_wr_fire;
    logic               w_wr_protected;
    logic               w_wr_commit;

    assign w_rd_offset   = bus.dr_addr - BASE_ADDR;
    assign w_wr_offset   = bus.dw_addr - BASE_ADDR;
    assign w_rd_in_range = (w_rd_offset < c_byte_span);
    assign w_wr_in_range = (w_wr_offset < c_byte_span);
    assign w_rd_idx      = w_rd_offset[c_idx_w+1:2];
    assign w_wr_idx      = w_wr_offset[c_idx_w+1:2];

    // Readies are only ever high in the IDLE states, and rst is folded in so
    // that no beat is taken on an edge that is resetting the FSMs.
    assign w_rd_fire = rst && bus.dr_addr_valid && bus.dr_addr_ready
                       && (r_rd_state == R_IDLE);
    assign w_wr_fire = rst && bus.dw_data_addr_valid && bus.dw_data_addr_ready
                       && (r_wr_state == W_IDLE);

`ifdef DATA_BUS_RESPONDER_WRITE_PROTECT_EN
    assign w_wr_protected = (32'(w_wr_idx) < RO_WORDS);
`else
    assign w_wr_protected = 1'b0;
`endif

    assign w_wr_commit = w_wr_fire && w_wr_in_range && !w_wr_protected;

    // ------------------------------------------------------------------
    // RAM write port: byte-masked, no reset on contents. A same-edge read of
    // the same word sees the old contents because both sides use NBAs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.dw_strobe[i]) begin
                    r_mem[w_wr_idx][8*i +: 8] <= bus.dw_data[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel FSM. The RAM word is captured at acceptance straight into
    // the dr_data register; the latency counter only delays dr_data_valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_state        <= R_IDLE;
            r_rd_cnt          <= 4'd0;
            bus.dr_addr_ready <= 1'b0;
            bus.dr_data_valid <= 1'b0;
            bus.dr_data       <= 32'h0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    bus.dr_addr_ready <= 1'b1;
                    if (w_rd_fire) begin
                        bus.dr_addr_ready <= 1'b0;
                        bus.dr_data       <= w_rd_in_range ? r_mem[w_rd_idx] : 32'h0;
                        r_rd_cnt          <= c_lat_init;
                        if (c_lat_init == 4'd0) begin
                            r_rd_state        <= R_RESP;
                            bus.dr_data_valid <= 1'b1;
                        end else begin
                            r_rd_state <= R_WAIT;
                        end
                    end
                end
                R_WAIT: begin
                    r_rd_cnt <= r_rd_cnt - 4'd1;
                    // Counter reaches zero on this edge: present the data.
                    if (r_rd_cnt == 4'd1) begin
                        r_rd_state        <= R_RESP;
                        bus.dr_data_valid <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (bus.dr_data_ready) begin
                        r_rd_state        <= R_IDLE;
                        bus.dr_data_valid <= 1'b0;
                    end
                end
                default: begin
                    r_rd_state        <= R_IDLE;
                    bus.dr_addr_ready <= 1'b0;
                    bus.dr_data_valid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write channel FSM. The RAM update happens on the acceptance edge, so
    // the response only reports what has already been done.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_state             <= W_IDLE;
            bus.dw_data_addr_ready <= 1'b0;
            bus.dw_resp_valid      <= 1'b0;
            bus.dw_resp            <= `DATA_WRITE_RESP_FAIL;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    bus.dw_data_addr_ready <= 1'b1;
                    if (w_wr_fire) begin
                        bus.dw_data_addr_ready <= 1'b0;
                        bus.dw_resp_valid      <= 1'b1;
                        bus.dw_resp            <= w_wr_commit ? `DATA_WRITE_RESP_OK
                                                              : `DATA_WRITE_RESP_FAIL;
                        r_wr_state             <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bus.dw_resp_ready) begin
                        bus.dw_resp_valid <= 1'b0;
                        r_wr_state        <= W_IDLE;
                    end
                end
                default: begin
                    r_wr_state             <= W_IDLE;
                    bus.dw_data_addr_ready <= 1'b0;
                    bus.dw_resp_valid      <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_bus_responder
// Description : Directed self-checking bench for data_bus_responder. Two
//               instances share clock and reset: dut_a (READ_LATENCY=1,
//               RO_WORDS=0) and dut_b (READ_LATENCY=4, RO_WORDS=4). The
//               stimulus variables are steered to one instance by sel and the
//               observed outputs are muxed back the same way.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_bus_responder;

    localparam logic [1:0] RESP_OK   = `DATA_WRITE_RESP_OK;
    localparam logic [1:0] RESP_FAIL = `DATA_WRITE_RESP_FAIL;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // stimulus
    logic        sel   = 1'b0;
    logic        rav   = 1'b0;
    logic [31:0] raddr = 32'h0;
    logic        rdr   = 1'b1;
    logic        wv    = 1'b0;
    logic [31:0] waddr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic        wrr   = 1'b1;

    data_bus_responder_if bus_a ();
    data_bus_responder_if bus_b ();

    data_bus_responder #(
        .DEPTH(1024), .BASE_ADDR(32'h0000_1000), .READ_LATENCY(1), .RO_WORDS(0)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    data_bus_responder #(
        .DEPTH(1024), .BASE_ADDR(32'h0000_1000), .READ_LATENCY(4), .RO_WORDS(4)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    assign bus_a.dr_addr_valid      = rav & ~sel;
    assign bus_a.dr_addr            = raddr;
    assign bus_a.dr_data_ready      = rdr;
    assign bus_a.dw_data_addr_valid = wv & ~sel;
    assign bus_a.dw_addr            = waddr;
    assign bus_a.dw_data            = wdata;
    assign bus_a.dw_strobe          = wstrb;
    assign bus_a.dw_resp_ready      = wrr;

    assign bus_b.dr_addr_valid      = rav & sel;
    assign bus_b.dr_addr            = raddr;
    assign bus_b.dr_data_ready      = rdr;
    assign bus_b.dw_data_addr_valid = wv & sel;
    assign bus_b.dw_addr            = waddr;
    assign bus_b.dw_data            = wdata;
    assign bus_b.dw_strobe          = wstrb;
    assign bus_b.dw_resp_ready      = wrr;

    logic        mon_arr, mon_dv, mon_war, mon_rv;
    logic [31:0] mon_dd;
    logic [1:0]  mon_resp;
    assign mon_arr  = sel ? bus_b.dr_addr_ready      : bus_a.dr_addr_ready;
    assign mon_dv   = sel ? bus_b.dr_data_valid      : bus_a.dr_data_valid;
    assign mon_dd   = sel ? bus_b.dr_data            : bus_a.dr_data;
    assign mon_war  = sel ? bus_b.dw_data_addr_ready : bus_a.dw_data_addr_ready;
    assign mon_rv   = sel ? bus_b.dw_resp_valid      : bus_a.dw_resp_valid;
    assign mon_resp = sel ? bus_b.dw_resp            : bus_a.dw_resp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One write beat with dw_resp_ready held high.
    task automatic bus_write(input string tag, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] exp_resp);
        int n;
        @(negedge clk);
        wv = 1'b1; waddr = addr; wdata = data; wstrb = strb;
        n = 0;
        while (!mon_war && n < 50) begin @(negedge clk); n++; end
        chk({tag, "/accept"}, 32'(mon_war), 32'd1);
        @(negedge clk);
        wv = 1'b0;
        chk({tag, "/resp_valid"}, 32'(mon_rv), 32'd1);
        chk({tag, "/resp"}, 32'(mon_resp), 32'(exp_resp));
        chk({tag, "/ready_low"}, 32'(mon_war), 32'd0);
        @(negedge clk);
        chk({tag, "/resp_clear"}, 32'(mon_rv), 32'd0);
    endtask

    // Issue a read address and wait for dr_data_valid; stops at the first
    // negedge where valid is seen.
    task automatic bus_read_req(input string tag, input logic [31:0] addr,
                                input int exp_lat, input logic check_data,
                                input logic [31:0] exp_data, output logic [31:0] got);
        int n;
        int lat;
        @(negedge clk);
        rav = 1'b1; raddr = addr;
        n = 0;
        while (!mon_arr && n < 50) begin @(negedge clk); n++; end
        chk({tag, "/accept"}, 32'(mon_arr), 32'd1);
        @(negedge clk);
        rav = 1'b0;
        lat = 1;
        while (!mon_dv && lat < 40) begin @(negedge clk); lat++; end
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        got = mon_dd;
        if (check_data) chk({tag, "/data"}, mon_dd, exp_data);
    endtask

    // With dr_data_ready high the handshake happens on the next edge; ready
    // returns one edge later.
    task automatic bus_read_done(input string tag);
        @(negedge clk);
        chk({tag, "/valid_clear"}, 32'(mon_dv), 32'd0);
        chk({tag, "/ready_still_low"}, 32'(mon_arr), 32'd0);
        @(negedge clk);
        chk({tag, "/ready_back"}, 32'(mon_arr), 32'd1);
    endtask

    task automatic bus_read(input string tag, input logic [31:0] addr,
                            input int exp_lat, input logic [31:0] exp_data);
        logic [31:0] got;
        bus_read_req(tag, addr, exp_lat, 1'b1, exp_data, got);
        bus_read_done(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] base_val;
        logic [31:0] got;
        int n;

        // ---------------- reset ----------------
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk($sformatf("rst%0d/dr_addr_ready", s), 32'(mon_arr), 32'd0);
            chk($sformatf("rst%0d/dr_data_valid", s), 32'(mon_dv), 32'd0);
            chk($sformatf("rst%0d/dr_data", s), mon_dd, 32'h0);
            chk($sformatf("rst%0d/dw_ready", s), 32'(mon_war), 32'd0);
            chk($sformatf("rst%0d/dw_resp_valid", s), 32'(mon_rv), 32'd0);
            chk($sformatf("rst%0d/dw_resp", s), 32'(mon_resp), 32'(RESP_FAIL));
        end
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk($sformatf("rel%0d/dr_addr_ready", s), 32'(mon_arr), 32'd1);
            chk($sformatf("rel%0d/dw_ready", s), 32'(mon_war), 32'd1);
        end
        sel = 1'b0;

        // ---------------- basic write / read, latency 1 ----------------
        bus_write("t1_wr", 32'h1000, 32'hDEAD_BEEF, 4'hF, RESP_OK);
        bus_read("t1_rd", 32'h1000, 1, 32'hDEAD_BEEF);

        // ---------------- byte strobe merge ----------------
        bus_write("t2_pre", 32'h1004, 32'h1122_3344, 4'hF, RESP_OK);
        bus_write("t2_wr", 32'h1004, 32'h0000_AB00, 4'b0010, RESP_OK);
        bus_read("t2_rd", 32'h1004, 1, 32'h1122_AB44);

        // ---------------- range boundaries ----------------
        bus_write("t3_last", 32'h1FFC, 32'hCAFE_F00D, 4'hF, RESP_OK);
        bus_write("t3_below", 32'h0FFC, 32'h1234_5678, 4'hF, RESP_FAIL);
        bus_write("t3_above", 32'h2000, 32'h1234_5678, 4'hF, RESP_FAIL);
        bus_read("t3_rd_below", 32'h0FFC, 1, 32'h0);
        bus_read("t3_rd_above", 32'h2000, 1, 32'h0);
        bus_read("t3_rd_first", 32'h1000, 1, 32'hDEAD_BEEF);
        bus_read("t3_rd_last", 32'h1FFC, 1, 32'hCAFE_F00D);

        // ---------------- zero strobe ----------------
        bus_write("t3_nostrb", 32'h1000, 32'hFFFF_FFFF, 4'h0, RESP_OK);
        bus_read("t3_rd_nostrb", 32'h1003, 1, 32'hDEAD_BEEF);

        // ---------------- same-cycle read and write ----------------
        bus_write("t5_pre", 32'h1008, 32'h0000_0005, 4'hF, RESP_OK);
        @(negedge clk);
        chk("t5/both_ready", {30'd0, mon_arr, mon_war}, 32'd3);
        rav = 1'b1; raddr = 32'h1008;
        wv = 1'b1; waddr = 32'h1008; wdata = 32'h0000_0009; wstrb = 4'hF;
        @(negedge clk);
        rav = 1'b0; wv = 1'b0;
        chk("t5/rd_valid", 32'(mon_dv), 32'd1);
        chk("t5/rd_old_data", mon_dd, 32'h0000_0005);
        chk("t5/wr_resp_valid", 32'(mon_rv), 32'd1);
        chk("t5/wr_resp", 32'(mon_resp), 32'(RESP_OK));
        repeat (2) @(negedge clk);
        bus_read("t5_rd_new", 32'h1008, 1, 32'h0000_0009);

        // ---------------- latency 4 with stalled data ready ----------------
        @(negedge clk);
        sel = 1'b1;
        bus_write("t4_wr", 32'h1020, 32'hA5A5_0001, 4'hF, RESP_OK);
        rdr = 1'b0;
        bus_read_req("t4_rd", 32'h1020, 4, 1'b1, 32'hA5A5_0001, got);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t4/stall%0d_valid", i), 32'(mon_dv), 32'd1);
            chk($sformatf("t4/stall%0d_data", i), mon_dd, 32'hA5A5_0001);
            chk($sformatf("t4/stall%0d_ready", i), 32'(mon_arr), 32'd0);
        end
        rdr = 1'b1;
        bus_read_done("t4_rd");

        // ---------------- write protection (dut_b, RO_WORDS=4) ----------------
        bus_read_req("t6_base", 32'h1000, 4, 1'b0, 32'h0, base_val);
        bus_read_done("t6_base");
`ifdef DATA_BUS_RESPONDER_WRITE_PROTECT_EN
        bus_write("t6_ro_wr", 32'h1000, 32'h0000_0007, 4'hF, RESP_FAIL);
        bus_read("t6_ro_rd", 32'h1000, 4, base_val);
`else
        bus_write("t6_ro_wr", 32'h1000, 32'h0000_0007, 4'hF, RESP_OK);
        bus_read("t6_ro_rd", 32'h1000, 4, 32'h0000_0007);
`endif
        bus_write("t6_rw_wr", 32'h1010, 32'hBEEF_0010, 4'hF, RESP_OK);
        bus_read("t6_rw_rd", 32'h1010, 4, 32'hBEEF_0010);

        // ---------------- reset during R_WAIT ----------------
        @(negedge clk);
        rav = 1'b1; raddr = 32'h1010;
        n = 0;
        while (!mon_arr && n < 50) begin @(negedge clk); n++; end
        chk("t6_abort/accept", 32'(mon_arr), 32'd1);
        @(negedge clk);
        rav = 1'b0;
        chk("t6_abort/waiting", 32'(mon_dv), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t6_abort/rst%0d_valid", i), 32'(mon_dv), 32'd0);
            chk($sformatf("t6_abort/rst%0d_ready", i), 32'(mon_arr), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("t6_abort/b_rd_ready", 32'(mon_arr), 32'd1);
        chk("t6_abort/b_wr_ready", 32'(mon_war), 32'd1);
        sel = 1'b0;
        #1;
        chk("t6_abort/a_rd_ready", 32'(mon_arr), 32'd1);
        chk("t6_abort/a_wr_ready", 32'(mon_war), 32'd1);
        sel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t6_abort/no_resp%0d", i), 32'(mon_dv), 32'd0);
        end
        bus_read("t6_ram_kept", 32'h1010, 4, 32'hBEEF_0010);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
